// File: rtl/comp_instr_decoder_pkg.sv
// RV32I opcode/funct constants, RVC quadrant enum and the immediate/format
// builders used to expand 16-bit RVC halfwords into 32-bit RV32I words.
package comp_instr_decoder_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    QUAD_0 = 2'b00,
    QUAD_1 = 2'b01,
    QUAD_2 = 2'b10,
    QUAD_3 = 2'b11
  } rvc_quad_e;

  // Builders take exactly the RVC bits they scramble, named by their slice.
  function automatic logic [11:0] imm_ciw(input logic [7:0] b);  // c[12:5]
    return {2'b00, b[5:2], b[7:6], b[0], b[1], 2'b00};
  endfunction

  function automatic logic [11:0] imm_cl(input logic [2:0] hi, input logic [1:0] lo);
    return {5'b0, lo[0], hi, lo[1], 2'b00};  // hi=c[12:10], lo=c[6:5]
  endfunction

  function automatic logic [11:0] imm_ci(input logic [5:0] b);  // {c[12],c[6:2]}
    return {{6{b[5]}}, b};
  endfunction

  function automatic logic [11:0] imm_ci16sp(input logic [5:0] b);
    return {{3{b[5]}}, b[2:1], b[3], b[0], b[4], 4'b0000};
  endfunction

  function automatic logic [19:0] imm_lui(input logic [5:0] b);
    return {{14{b[5]}}, b};
  endfunction

  function automatic logic [20:0] imm_cj(input logic [10:0] b);  // c[12:2]
    return {{9{b[10]}}, b[10], b[6], b[8:7], b[4], b[5], b[0], b[9], b[3:1], 1'b0};
  endfunction

  function automatic logic [12:0] imm_cb(input logic [2:0] hi, input logic [4:0] lo);
    return {{4{hi[2]}}, hi[2], lo[4:3], lo[0], hi[1:0], lo[2:1], 1'b0};
  endfunction

  function automatic logic [11:0] imm_lwsp(input logic [5:0] b);
    return {4'b0, b[1:0], b[5], b[4:2], 2'b00};
  endfunction

  function automatic logic [11:0] imm_swsp(input logic [5:0] b);  // c[12:7]
    return {4'b0, b[1:0], b[5:2], 2'b00};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/comp_instr_decoder.sv
// Combinational RVC -> RV32I expander with illegal detection and sticky flag.
// Optional: CDEC_ILLEGAL_DETECT_EN enables the illegal / illegal_sticky outputs.
module comp_instr_decoder
  import comp_instr_decoder_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] instruction,
  output logic [31:0] decomp_instruction,
  output logic        is_compressed,
  output logic        illegal,
  output logic        illegal_sticky
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [5:0]  ci_b;
  logic [31:0] expd;
  logic        ill_raw;

  assign c    = instruction;
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};
  assign ci_b = {c[12], c[6:2]};

  always_comb begin
    expd    = 32'h0;
    ill_raw = 1'b0;
    unique case (rvc_quad_e'(c[1:0]))
      QUAD_0: begin
        unique case (c[15:13])
          3'b000: begin
            ill_raw = (c[12:5] == 8'h00);  // also catches the all-zero halfword
            expd    = enc_i(imm_ciw(c[12:5]), 5'd2, F3_ADD, rdp, OPC_OP_IMM);
          end
          3'b010:  expd = enc_i(imm_cl(c[12:10], c[6:5]), rs1p, F3_LW, rdp, OPC_LOAD);
          3'b110:  expd = enc_s(imm_cl(c[12:10], c[6:5]), rdp, rs1p);
          default: ill_raw = 1'b1;
        endcase
      end
      QUAD_1: begin
        unique case (c[15:13])
          3'b000: expd = enc_i(imm_ci(ci_b), rd, F3_ADD, rd, OPC_OP_IMM);
          3'b001: expd = enc_j(imm_cj(c[12:2]), 5'd1);
          3'b010: expd = enc_i(imm_ci(ci_b), 5'd0, F3_ADD, rd, OPC_OP_IMM);
          3'b011: begin
            ill_raw = (ci_b == 6'd0);
            if (rd == 5'd2) expd = enc_i(imm_ci16sp(ci_b), 5'd2, F3_ADD, 5'd2, OPC_OP_IMM);
            else            expd = {imm_lui(ci_b), rd, OPC_LUI};
          end
          3'b100: begin
            unique case (c[11:10])
              2'b00: begin
                ill_raw = c[12];
                expd    = enc_r(F7_BASE, c[6:2], rs1p, F3_SRL, rs1p, OPC_OP_IMM);
              end
              2'b01: begin
                ill_raw = c[12];
                expd    = enc_r(F7_ALT, c[6:2], rs1p, F3_SRL, rs1p, OPC_OP_IMM);
              end
              2'b10: expd = enc_i(imm_ci(ci_b), rs1p, F3_AND, rs1p, OPC_OP_IMM);
              default: begin
                ill_raw = c[12];  // RV64-only SUBW/ADDW and reserved slots
                unique case (c[6:5])
                  2'b00:   expd = enc_r(F7_ALT,  rdp, rs1p, F3_ADD, rs1p, OPC_OP);
                  2'b01:   expd = enc_r(F7_BASE, rdp, rs1p, F3_XOR, rs1p, OPC_OP);
                  2'b10:   expd = enc_r(F7_BASE, rdp, rs1p, F3_OR,  rs1p, OPC_OP);
                  default: expd = enc_r(F7_BASE, rdp, rs1p, F3_AND, rs1p, OPC_OP);
                endcase
              end
            endcase
          end
          3'b101:  expd = enc_j(imm_cj(c[12:2]), 5'd0);
          3'b110:  expd = enc_b(imm_cb(c[12:10], c[6:2]), rs1p, F3_BEQ);
          default: expd = enc_b(imm_cb(c[12:10], c[6:2]), rs1p, F3_BNE);
        endcase
      end
      QUAD_2: begin
        unique case (c[15:13])
          3'b000: begin
            ill_raw = c[12];
            expd    = enc_r(F7_BASE, c[6:2], rd, F3_SLL, rd, OPC_OP_IMM);
          end
          3'b010: begin
            ill_raw = (rd == 5'd0);
            expd    = enc_i(imm_lwsp(ci_b), 5'd2, F3_LW, rd, OPC_LOAD);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin
                ill_raw = (rd == 5'd0);
                expd    = enc_i(12'd0, rd, 3'b000, 5'd0, OPC_JALR);
              end else begin
                expd = enc_r(F7_BASE, rs2, 5'd0, F3_ADD, rd, OPC_OP);
              end
            end else if (rs2 == 5'd0) begin
              if (rd == 5'd0) expd = INSN_EBREAK;
              else            expd = enc_i(12'd0, rd, 3'b000, 5'd1, OPC_JALR);
            end else begin
              expd = enc_r(F7_BASE, rs2, rd, F3_ADD, rd, OPC_OP);
            end
          end
          3'b110:  expd = enc_s(imm_swsp(c[12:7]), rs2, 5'd2);
          default: ill_raw = 1'b1;
        endcase
      end
      default: expd = {16'h0, c};
    endcase
  end

  assign decomp_instruction = ill_raw ? 32'h0 : expd;
  assign is_compressed      = (c[1:0] != 2'b11);

`ifdef CDEC_ILLEGAL_DETECT_EN
  assign illegal = ill_raw;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     illegal_sticky <= 1'b0;
    else if (ill_raw) illegal_sticky <= 1'b1;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = aclk ^ aresetn;
  assign illegal        = 1'b0;
  assign illegal_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_comp_instr_decoder.sv
// Directed bench for comp_instr_decoder; illegal expectations follow
// whether CDEC_ILLEGAL_DETECT_EN is defined for the build.
module tb_comp_instr_decoder;

`ifdef CDEC_ILLEGAL_DETECT_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic        aclk;
  logic        aresetn;
  logic [15:0] instruction;
  logic [31:0] decomp_instruction;
  logic        is_compressed;
  logic        illegal;
  logic        illegal_sticky;

  int n_vec = 0;
  int n_err = 0;

  comp_instr_decoder dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .instruction        (instruction),
    .decomp_instruction (decomp_instruction),
    .is_compressed      (is_compressed),
    .illegal            (illegal),
    .illegal_sticky     (illegal_sticky)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one halfword away from the clock edge and check all decode outputs.
  task automatic apply(input string tag, input logic [15:0] vec, input logic [31:0] exp_d,
                       input logic exp_c, input logic exp_i);
    @(negedge aclk);
    instruction = vec;
    #1;
    chk({tag, ".decomp"}, decomp_instruction, exp_d);
    chk({tag, ".is_c"},   {31'b0, is_compressed}, {31'b0, exp_c});
    chk({tag, ".ill"},    {31'b0, illegal}, {31'b0, exp_i});
  endtask

  initial begin
    aresetn     = 1'b0;
    instruction = 16'h0001;
    #12;
    chk("reset.sticky", {31'b0, illegal_sticky}, 32'd0);
    chk("reset.decomp", decomp_instruction, 32'h0000_0013);
    @(negedge aclk);
    aresetn = 1'b1;

    apply("c_nop",      16'h0001, 32'h0000_0013, 1'b1, 1'b0);
    apply("c_li",       16'h4515, 32'h0050_0513, 1'b1, 1'b0);
    apply("c_lw",       16'h4188, 32'h0005_A503, 1'b1, 1'b0);
    apply("c_mv",       16'h852E, 32'h00B0_0533, 1'b1, 1'b0);
    apply("c_ebreak",   16'h9002, 32'h0010_0073, 1'b1, 1'b0);
    apply("q3_pass",    16'h0013, 32'h0000_0013, 1'b0, 1'b0);
    apply("c_j_neg2",   16'hBFFD, 32'hFFFF_F06F, 1'b1, 1'b0);
    apply("c_beqz",     16'hC109, 32'h0005_0163, 1'b1, 1'b0);
    apply("c_addi16sp", 16'h7139, 32'hFC01_0113, 1'b1, 1'b0);
    apply("c_sub",      16'h8D0D, 32'h40B5_0533, 1'b1, 1'b0);
    apply("c_swsp",     16'hC22A, 32'h00A1_2223, 1'b1, 1'b0);
    apply("hint_li_x0", 16'h4015, 32'h0050_0013, 1'b1, 1'b0);
    @(posedge aclk);
    #1;
    chk("sticky.clean", {31'b0, illegal_sticky}, 32'd0);

    apply("zero",       16'h0000, 32'h0000_0000, 1'b1, ILL_EN);
    @(posedge aclk);
    #1;
    chk("sticky.set", {31'b0, illegal_sticky}, {31'b0, ILL_EN});

    apply("addi4spn_0", 16'h0004, 32'h0000_0000, 1'b1, ILL_EN);
    apply("lui_nz0",    16'h6181, 32'h0000_0000, 1'b1, ILL_EN);
    apply("srai_b5",    16'h9405, 32'h0000_0000, 1'b1, ILL_EN);
    apply("lwsp_rd0",   16'h4002, 32'h0000_0000, 1'b1, ILL_EN);
    apply("jr_rs0",     16'h8002, 32'h0000_0000, 1'b1, ILL_EN);
    apply("c_li_back",  16'h4515, 32'h0050_0513, 1'b1, 1'b0);
    @(posedge aclk);
    #1;
    chk("sticky.hold", {31'b0, illegal_sticky}, {31'b0, ILL_EN});

    // Asynchronous clear between clock edges; decode must keep running.
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("sticky.async_clr", {31'b0, illegal_sticky}, 32'd0);
    chk("decomp.in_reset", decomp_instruction, 32'h0050_0513);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("sticky.after_rst", {31'b0, illegal_sticky}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
